// File: rtl/fft_pkg.sv
// Shared definitions for the pipelined radix-2 SDF FFT stages.
package fft_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } sdf_state_e;

  // Elaboration-time ceil(log2(value)); clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >>> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/sdf_delay_line.sv
// Complex feedback delay line for one SDF stage: DEPTH-deep shift register,
// both components packed as {re, im}; head is the oldest entry.
module sdf_delay_line
  import fft_pkg::*;
#(
  parameter int WIDTH = 23,
  parameter int DEPTH = 16
) (
  input  logic               clk,
  input  logic               shift,
  input  logic [2*WIDTH-1:0] din,
  output logic [2*WIDTH-1:0] head
);

  logic [2*WIDTH-1:0] line_q [DEPTH];

  // NOTE: the storage has no reset; the control logic never emits an entry
  // that was not written after reset, so clearing it would only cost area.
  always_ff @(posedge clk) begin
    if (shift) begin
      line_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        line_q[i] <= line_q[i-1];
      end
    end
  end

  assign head = line_q[DEPTH-1];

endmodule

// File: rtl/sdf_r2_stage.sv
// Radix-2 SDF butterfly stage: frame counter, RUN/DRAIN control, butterfly
// with optional halving, and registered outputs tagged with a frame index.
module sdf_r2_stage
  import fft_pkg::*;
#(
  parameter  int DATA_W = 22,
  parameter  int DELAY  = 16,
  parameter  int SCALE  = 1,
  localparam int OUT_W  = DATA_W + 1 - SCALE,
  localparam int IDX_W  = clog2(2 * DELAY)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_real,
  input  logic signed [DATA_W-1:0] in_imag,
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  out_real,
  output logic signed [OUT_W-1:0]  out_imag,
  output logic [IDX_W-1:0]         out_idx,
  output logic                     out_last
);

  typedef struct packed {
    logic signed [OUT_W-1:0] re;
    logic signed [OUT_W-1:0] im;
  } cplx_t;

  localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);
  localparam logic [IDX_W-1:0] D_IDX    = IDX_W'(DELAY);
  localparam logic [IDX_W-1:0] HALF_END = IDX_W'(DELAY - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * DELAY - 1);

  sdf_state_e       state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] drain_k_q, drain_k_d;
  logic             pend_q, pend_d;
  logic             ready_q, ready_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  cplx_t            out_q, out_d;

  cplx_t            head, push;
  logic             shift;
  logic             accept;
  logic             phase_b;

  logic signed [DATA_W:0] sum_re, sum_im, dif_re, dif_im;

  sdf_delay_line #(
    .WIDTH (OUT_W),
    .DEPTH (DELAY)
  ) u_line (
    .clk   (clk),
    .shift (shift),
    .din   (push),
    .head  (head)
  );

  // In phase B the head holds a sign-extended input, so its low DATA_W bits
  // carry the full value.
  assign sum_re = (DATA_W+1)'($signed(head.re[DATA_W-1:0])) + (DATA_W+1)'(in_real);
  assign sum_im = (DATA_W+1)'($signed(head.im[DATA_W-1:0])) + (DATA_W+1)'(in_imag);
  assign dif_re = (DATA_W+1)'($signed(head.re[DATA_W-1:0])) - (DATA_W+1)'(in_real);
  assign dif_im = (DATA_W+1)'($signed(head.im[DATA_W-1:0])) - (DATA_W+1)'(in_imag);

  assign accept  = in_valid && ready_q;
  assign phase_b = (cnt_q >= D_IDX);

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    drain_k_d   = drain_k_q;
    pend_d      = pend_q;
    ready_d     = ready_q;
    shift       = 1'b0;
    push        = '0;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    out_idx_d   = out_idx_q;
    out_d       = out_q;

    unique case (state_q)
      ST_RUN: begin
        ready_d = 1'b1;
        if (accept) begin
          shift = 1'b1;
          cnt_d = cnt_q + ONE;
          if (!phase_b) begin
            push.re = OUT_W'(in_real);
            push.im = OUT_W'(in_imag);
            if (pend_q) begin
              out_valid_d = 1'b1;
              out_d       = head;
              out_idx_d   = D_IDX + cnt_q;
              out_last_d  = (cnt_q == HALF_END);
            end
            if (cnt_q == HALF_END) pend_d = 1'b0;
          end else begin
            // Slicing from bit SCALE is the floor halving when SCALE = 1.
            push.re     = dif_re[DATA_W:SCALE];
            push.im     = dif_im[DATA_W:SCALE];
            out_valid_d = 1'b1;
            out_d.re    = sum_re[DATA_W:SCALE];
            out_d.im    = sum_im[DATA_W:SCALE];
            out_idx_d   = cnt_q - D_IDX;
            if (cnt_q == LAST_IDX) pend_d = 1'b1;
          end
        end else if (cnt_q == '0 && pend_q && !in_valid) begin
          state_d   = ST_DRAIN;
          ready_d   = 1'b0;
          drain_k_d = '0;
        end
      end

      ST_DRAIN: begin
        ready_d     = 1'b0;
        shift       = 1'b1;
        out_valid_d = 1'b1;
        out_d       = head;
        out_idx_d   = D_IDX + drain_k_q;
        out_last_d  = (drain_k_q == HALF_END);
        drain_k_d   = drain_k_q + ONE;
        if (drain_k_q == HALF_END) begin
          state_d   = ST_RUN;
          pend_d    = 1'b0;
          ready_d   = 1'b1;
          drain_k_d = '0;
        end
      end

      default: state_d = ST_RUN;
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so every
  // register samples the pre-edge values computed above.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      drain_k_q   <= '0;
      pend_q      <= 1'b0;
      ready_q     <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_idx_q   <= '0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      drain_k_q   <= drain_k_d;
      pend_q      <= pend_d;
      ready_q     <= ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_idx_q   <= out_idx_d;
      out_q       <= out_d;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_idx   = out_idx_q;
  assign out_real  = out_q.re;
  assign out_imag  = out_q.im;

endmodule

// File: tb/tb_sdf_r2_stage.sv
// Bench for sdf_r2_stage: an unscaled and a halving instance share stimulus;
// outputs are compared against per-frame sum/difference expectations.
`timescale 1ns/1ps
module tb_sdf_r2_stage;

  localparam int D  = 4;
  localparam int DW = 16;
  localparam int N  = 2 * D;

  typedef struct {
    int re;
    int im;
    int idx;
    bit last;
    int cyc;
  } smp_t;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic signed [DW-1:0] in_real, in_imag;
  logic rdy0, rdy1, v0, v1, l0, l1;
  logic signed [DW:0]   r0, i0;
  logic signed [DW-1:0] r1, i1;
  logic [2:0] x0, x1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_low = 0;
  int first_acc = 0;
  int acc_cyc = 0;

  smp_t obs_q[2][$];
  smp_t exp_q[2][$];
  int fr_re[N];
  int fr_im[N];
  int gap[N];

  sdf_r2_stage #(.DATA_W(DW), .DELAY(D), .SCALE(0)) u_s0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
    .in_real(in_real), .in_imag(in_imag), .out_valid(v0),
    .out_real(r0), .out_imag(i0), .out_idx(x0), .out_last(l0)
  );

  sdf_r2_stage #(.DATA_W(DW), .DELAY(D), .SCALE(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .in_real(in_real), .in_imag(in_imag), .out_valid(v1),
    .out_real(r1), .out_imag(i1), .out_idx(x1), .out_last(l1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rdy0 === 1'b0) ready_low++;
    if (v0 === 1'b1) obs_q[0].push_back('{int'(r0), int'(i0), int'(x0), l0, cyc});
    if (v1 === 1'b1) obs_q[1].push_back('{int'(r1), int'(i1), int'(x1), l1, cyc});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int floor_half(input int v);
    return (v - (v & 1)) / 2;
  endfunction

  function automatic smp_t mk(input int s, input int re, input int im, input int idx);
    smp_t e;
    e.re   = (s == 1) ? floor_half(re) : re;
    e.im   = (s == 1) ? floor_half(im) : im;
    e.idx  = idx;
    e.last = (idx == N - 1);
    e.cyc  = 0;
    return e;
  endfunction

  // A frame x[0..2D-1] yields sums x[i]+x[i+D] (idx i), then differences
  // x[i]-x[i+D] (idx D+i), in that order.
  task automatic model_frame();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < D; i++)
        exp_q[s].push_back(mk(s, fr_re[i] + fr_re[i+D], fr_im[i] + fr_im[i+D], i));
      for (int i = 0; i < D; i++)
        exp_q[s].push_back(mk(s, fr_re[i] - fr_re[i+D], fr_im[i] - fr_im[i+D], D + i));
    end
  endtask

  function automatic bit smp_eq(input smp_t a, input smp_t b);
    return a.re == b.re && a.im == b.im && a.idx == b.idx && a.last == b.last;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic clear_all();
    for (int s = 0; s < 2; s++) begin
      obs_q[s].delete();
      exp_q[s].delete();
    end
    ready_low = 0;
  endtask

  task automatic set_frame(input int base_re, input int base_im);
    for (int i = 0; i < N; i++) begin
      fr_re[i] = base_re + i;
      fr_im[i] = base_im;
      gap[i]   = 0;
    end
  endtask

  task automatic wait_accept();
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    do begin
      @(negedge clk);
      ok = (rdy0 === 1'b1);
      acc_cyc = cyc;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 100);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed %b for %0d cycles, required 1", rdy0, n);
    end
  endtask

  task automatic send_frame(input int n, input bit hold_valid);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_real  = DW'(fr_re[i]);
      in_imag  = DW'(fr_im[i]);
      wait_accept();
      if (i == 0) first_acc = acc_cyc;
      if (gap[i] > 0) begin
        in_valid = 1'b0;
        repeat (gap[i]) @(posedge clk);
        #1;
      end
    end
    if (!hold_valid) in_valid = 1'b0;
  endtask

  task automatic idle_wait();
    in_valid = 1'b0;
    repeat (3 * D + 4) @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_real = '0;
    in_imag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({v0, l0, x0, r0, i0} !== '0 || rdy0 !== 1'b1) begin
      errors++;
      $display("FAIL reset_s0: valid=%b last=%b idx=%0d re=%0d im=%0d ready=%b, required 0/0/0/0/0 ready=1",
               v0, l0, x0, r0, i0, rdy0);
    end
    checks++;
    if ({v1, l1, x1, r1, i1} !== '0 || rdy1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_s1: valid=%b last=%b idx=%0d re=%0d im=%0d ready=%b, required 0/0/0/0/0 ready=1",
               v1, l1, x1, r1, i1, rdy1);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_single_frame();
    int lat;
    clear_all();
    set_frame(1, 0);
    model_frame();
    send_frame(N, 1'b0);
    idle_wait();
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (obs_q[s].size() != exp_q[s].size()) begin
        errors++;
        $display("FAIL single_count s%0d: got %0d outputs, required %0d", s, obs_q[s].size(), exp_q[s].size());
      end
      for (int i = 0; i < exp_q[s].size() && i < obs_q[s].size(); i++) begin
        checks++;
        if (!smp_eq(obs_q[s][i], exp_q[s][i])) begin
          errors++;
          $display("FAIL single_out%0d s%0d: got (%0d,%0d) idx %0d last %0d, required (%0d,%0d) idx %0d last %0d",
                   i, s, obs_q[s][i].re, obs_q[s][i].im, obs_q[s][i].idx, obs_q[s][i].last,
                   exp_q[s][i].re, exp_q[s][i].im, exp_q[s][i].idx, exp_q[s][i].last);
        end
      end
    end
    lat = (obs_q[0].size() > 0) ? obs_q[0][0].cyc - first_acc : -1;
    checks++;
    if (lat != D + 1) begin
      errors++;
      $display("FAIL single_latency: got %0d cycles, required %0d", lat, D + 1);
    end
    checks++;
    if (ready_low != D) begin
      errors++;
      $display("FAIL single_drain_ready: in_ready low %0d cycles, required %0d", ready_low, D);
    end
    lat = (obs_q[0].size() >= N) ? obs_q[0][N-1].cyc - obs_q[0][D].cyc : -1;
    checks++;
    if (lat != D - 1) begin
      errors++;
      $display("FAIL single_drain_span: got %0d cycles, required %0d", lat, D - 1);
    end
  endtask

  task automatic test_scale_floor();
    clear_all();
    set_frame(0, 0);
    for (int i = 0; i < N; i++) fr_re[i] = 0;
    fr_re[0] = 1;
    fr_re[D] = 2;
    model_frame();
    send_frame(N, 1'b0);
    idle_wait();
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (obs_q[s].size() != exp_q[s].size()) begin
        errors++;
        $display("FAIL floor_count s%0d: got %0d outputs, required %0d", s, obs_q[s].size(), exp_q[s].size());
      end
      for (int i = 0; i < exp_q[s].size() && i < obs_q[s].size(); i++) begin
        checks++;
        if (!smp_eq(obs_q[s][i], exp_q[s][i])) begin
          errors++;
          $display("FAIL floor_out%0d s%0d: got (%0d,%0d) idx %0d last %0d, required (%0d,%0d) idx %0d last %0d",
                   i, s, obs_q[s][i].re, obs_q[s][i].im, obs_q[s][i].idx, obs_q[s][i].last,
                   exp_q[s][i].re, exp_q[s][i].im, exp_q[s][i].idx, exp_q[s][i].last);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int low_mid;
    clear_all();
    set_frame(1, 0);
    model_frame();
    send_frame(N, 1'b1);
    set_frame(11, 0);
    model_frame();
    send_frame(N, 1'b1);
    low_mid = ready_low;
    idle_wait();
    checks++;
    if (low_mid != 0) begin
      errors++;
      $display("FAIL b2b_ready: in_ready low %0d cycles between frames, required 0", low_mid);
    end
    checks++;
    if (ready_low != D) begin
      errors++;
      $display("FAIL b2b_final_drain: in_ready low %0d cycles, required %0d", ready_low, D);
    end
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (obs_q[s].size() != exp_q[s].size()) begin
        errors++;
        $display("FAIL b2b_count s%0d: got %0d outputs, required %0d", s, obs_q[s].size(), exp_q[s].size());
      end
      for (int i = 0; i < exp_q[s].size() && i < obs_q[s].size(); i++) begin
        checks++;
        if (!smp_eq(obs_q[s][i], exp_q[s][i])) begin
          errors++;
          $display("FAIL b2b_out%0d s%0d: got (%0d,%0d) idx %0d last %0d, required (%0d,%0d) idx %0d last %0d",
                   i, s, obs_q[s][i].re, obs_q[s][i].im, obs_q[s][i].idx, obs_q[s][i].last,
                   exp_q[s][i].re, exp_q[s][i].im, exp_q[s][i].idx, exp_q[s][i].last);
        end
      end
    end
  endtask

  task automatic test_gaps();
    int lat;
    clear_all();
    set_frame(1, 0);
    gap[1] = 3;
    gap[5] = 3;
    model_frame();
    send_frame(N, 1'b0);
    idle_wait();
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (obs_q[s].size() != exp_q[s].size()) begin
        errors++;
        $display("FAIL gaps_count s%0d: got %0d outputs, required %0d", s, obs_q[s].size(), exp_q[s].size());
      end
      for (int i = 0; i < exp_q[s].size() && i < obs_q[s].size(); i++) begin
        checks++;
        if (!smp_eq(obs_q[s][i], exp_q[s][i])) begin
          errors++;
          $display("FAIL gaps_out%0d s%0d: got (%0d,%0d) idx %0d last %0d, required (%0d,%0d) idx %0d last %0d",
                   i, s, obs_q[s][i].re, obs_q[s][i].im, obs_q[s][i].idx, obs_q[s][i].last,
                   exp_q[s][i].re, exp_q[s][i].im, exp_q[s][i].idx, exp_q[s][i].last);
        end
      end
    end
    lat = (obs_q[0].size() > 0) ? obs_q[0][0].cyc - first_acc : -1;
    checks++;
    if (lat != D + 1 + 3) begin
      errors++;
      $display("FAIL gaps_stall: first sum after %0d cycles, required %0d", lat, D + 4);
    end
  endtask

  task automatic test_reset_mid();
    set_frame(1, 0);
    send_frame(6, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({v0, l0, x0, r0, i0, v1, l1, x1, r1, i1} !== '0 || rdy0 !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_outputs: valid=%b/%b re=%0d/%0d idx=%0d/%0d ready=%b, required zeros and ready=1",
               v0, v1, r0, r1, x0, x1, rdy0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_all();
    model_frame();
    send_frame(N, 1'b0);
    idle_wait();
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (obs_q[s].size() != exp_q[s].size()) begin
        errors++;
        $display("FAIL rstmid_count s%0d: got %0d outputs, required %0d", s, obs_q[s].size(), exp_q[s].size());
      end
      for (int i = 0; i < exp_q[s].size() && i < obs_q[s].size(); i++) begin
        checks++;
        if (!smp_eq(obs_q[s][i], exp_q[s][i])) begin
          errors++;
          $display("FAIL rstmid_out%0d s%0d: got (%0d,%0d) idx %0d last %0d, required (%0d,%0d) idx %0d last %0d",
                   i, s, obs_q[s][i].re, obs_q[s][i].im, obs_q[s][i].idx, obs_q[s][i].last,
                   exp_q[s][i].re, exp_q[s][i].im, exp_q[s][i].idx, exp_q[s][i].last);
        end
      end
    end
  endtask

  task automatic test_imag_growth();
    clear_all();
    for (int i = 0; i < N; i++) begin
      fr_re[i] = (i < D) ? 32767 : -32768;
      fr_im[i] = fr_re[i];
      gap[i]   = 0;
    end
    model_frame();
    send_frame(N, 1'b0);
    idle_wait();
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (obs_q[s].size() != exp_q[s].size()) begin
        errors++;
        $display("FAIL imag_count s%0d: got %0d outputs, required %0d", s, obs_q[s].size(), exp_q[s].size());
      end
      for (int i = 0; i < exp_q[s].size() && i < obs_q[s].size(); i++) begin
        checks++;
        if (!smp_eq(obs_q[s][i], exp_q[s][i])) begin
          errors++;
          $display("FAIL imag_out%0d s%0d: got (%0d,%0d) idx %0d last %0d, required (%0d,%0d) idx %0d last %0d",
                   i, s, obs_q[s][i].re, obs_q[s][i].im, obs_q[s][i].idx, obs_q[s][i].last,
                   exp_q[s][i].re, exp_q[s][i].im, exp_q[s][i].idx, exp_q[s][i].last);
        end
      end
    end
  endtask

  task automatic test_random();
    bit hold;
    clear_all();
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < N; i++) begin
        fr_re[i] = int'($urandom_range(0, 65535)) - 32768;
        fr_im[i] = int'($urandom_range(0, 65535)) - 32768;
        gap[i]   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      end
      hold = (f < 7) ? 1'($urandom_range(0, 1)) : 1'b0;
      model_frame();
      send_frame(N, hold);
      if (!hold) begin
        repeat ($urandom_range(0, D + 2)) @(posedge clk);
        #1;
      end
    end
    idle_wait();
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (obs_q[s].size() != exp_q[s].size()) begin
        errors++;
        $display("FAIL random_count s%0d: got %0d outputs, required %0d", s, obs_q[s].size(), exp_q[s].size());
      end
      for (int i = 0; i < exp_q[s].size() && i < obs_q[s].size(); i++) begin
        checks++;
        if (!smp_eq(obs_q[s][i], exp_q[s][i])) begin
          errors++;
          $display("FAIL random_out%0d s%0d: got (%0d,%0d) idx %0d last %0d, required (%0d,%0d) idx %0d last %0d",
                   i, s, obs_q[s][i].re, obs_q[s][i].im, obs_q[s][i].idx, obs_q[s][i].last,
                   exp_q[s][i].re, exp_q[s][i].im, exp_q[s][i].idx, exp_q[s][i].last);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_scale_floor();
    test_back_to_back();
    test_gaps();
    test_reset_mid();
    test_imag_growth();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdf_r2_stage.md
# sdf_r2_stage

Parametrised radix-2 single-path-delay-feedback (SDF) butterfly stage with an internal complex delay line, optional 1-bit scaling, an input-ready handshake and automatic end-of-frame drain. One instance sits at each stage of the pipelined FFT, with `DELAY` halving from stage to stage. Each output carries a frame-relative index so the downstream twiddle multiplier can address its ROM.

## Interface
- `DATA_W`, default 22: input sample width per component, two's complement.
- `DELAY`, default 16: delay-line depth D, a power of two ≥1; frame length is 2D.
- `SCALE`, default 1: 1 divides butterfly results by 2; 0 keeps full growth.
- Derived: `OUT_W = DATA_W + 1 - SCALE`, `IDX_W = clog2(2*DELAY)`.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  sample present; accepted when `in_valid && in_ready`.
- `in_ready`  out  1  stage can accept a sample.
- `in_real`, `in_imag`  in  DATA_W  sample.
- `out_valid`  out  1  output sample valid; no downstream backpressure.
- `out_real`, `out_imag`  out  OUT_W  butterfly result.
- `out_idx`  out  IDX_W  output index: 0..D-1 sums, D..2D-1 differences.
- `out_last`  out  1  asserted with `out_idx == 2D-1`.

## Operation
- **Sample counter `cnt`** (0..2D-1) advances only on an accepted input and wraps at 2D.
  - Phase A: `cnt < D`.
  - Phase B: `cnt >= D`.
- **Delay line**: a D-deep shift register, OUT_W per component. It shifts by one on each accepted input or drain step; `head` is the oldest entry.
- **Phase A, accept x**:
  - Push x, sign-extended to OUT_W.
  - If `pend`: output `head` (the previous frame's difference) with `out_idx = D + cnt`.
  - Otherwise no output.
- **Phase B, accept x**:
  - Output `(head + x)` with `out_idx = cnt - D`.
  - Push `(head - x)`.
  - Sum and difference are computed at DATA_W+1 bits. With `SCALE=1`, apply an arithmetic shift right by 1 (floor).
- **`pend`**:
  - Set on acceptance at `cnt == 2D-1`.
  - Cleared on acceptance at `cnt == D-1`, or on the last drain step.
- **States**:
  - RUN → DRAIN: at the first cycle after a frame end where `cnt == 0 && pend && !in_valid`.
  - DRAIN:
    - `in_ready = 0`.
    - Each cycle shifts the line, pushes 0 and outputs `head` with `out_idx = D + k`, k = 0..D-1.
    - Returns to RUN after D steps; `pend` cleared.
  - Back-to-back frames: if `in_valid` is high at `cnt == 0`, DRAIN is never entered and differences interleave with the next frame's phase A.
- **Mid-frame gaps**: `in_valid` low with `cnt != 0` freezes everything, and no output is produced.
- **Reset**:
  - `cnt = 0`, state RUN, `pend = 0`.
  - `out_valid = 0`, `out_last = 0`, `out_idx = 0`, `out_real = out_imag = 0`, `in_ready = 1`.
  - Delay-line contents are don't-care. Reset mid-frame or mid-drain discards the partial frame; no stale difference is ever emitted.

## Timing
- All outputs are registered. An output appears one cycle after the accepting or drain cycle.
- `in_ready` is registered: it falls in the same cycle DRAIN is entered and rises in the cycle after the last drain step.
- Frame throughput: 2D accepted cycles, plus D drain cycles only when frames are not back-to-back.
- Latency from a frame's first sample to its first sum: D+1 cycles with gapless input.
- `out_last` pulses once per frame, on the final difference.

## Structure
- Shared package `fft_pkg`:
  - complex sample typedef parametrised by width;
  - `clog2` function;
  - phase/state encodings `ST_RUN`, `ST_DRAIN`.
- Sub-module `sdf_delay_line`: parameters `WIDTH`, `DEPTH`; ports `shift`, `din` (complex), `head`. Implement as a shift register (small D) or a circular RAM with pointer; behaviour is identical.
- The top holds the counter, FSM, butterfly adder/subtractor, scaler and output registers.

## Test plan
All scenarios use D=4, DATA_W=16, real inputs, imag = 0, unless stated.
- **Single frame, SCALE=0**: x = 1..8 gapless → sums 6, 8, 10, 12 (idx 0–3), then drain with `in_ready = 0` for 4 cycles → -4 ×4 (idx 4–7); `out_last` on the final one.
- **SCALE=1**: same frame → sums 3, 4, 5, 6 and differences -2. Frame (1, 0, 0, 0, 2, 0, 0, 0) → sum floor(3/2) = 1, difference floor(-1/2) = -1.
- **Back-to-back**: two gapless frames 1..8 then 11..18 → frame-0 differences appear during frame-1 phase A, `in_ready` never drops; frame-1 sums are 26, 28, 30, 32.
- **Gaps**: frame 1..8 with `in_valid` deasserted 3 cycles after sample 2 and after sample 6 → identical value/idx sequence, outputs stalled accordingly.
- **Reset mid-frame**: assert `rst` after sample 6 of a frame, then send frame 1..8 → no output until sums 6, 8, 10, 12; all outputs 0 during reset.
- **Imag path / saturation-free growth**: x = (32767 + 32767j) ×4, then (-32768 - 32768j) ×4, SCALE=0 → sums -1 - 1j, differences 65535 + 65535j (17-bit).
